// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the two-port DRAM arbiter: FSM encoding,
// port indices and default widths.
package dram_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_WRITE = 3'd2,
        S_READ  = 3'd3,
        S_RDATA = 3'd4,
        S_ACK   = 3'd5
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;
    localparam int SETUP_MAX = 3;

endpackage

// File: rtl/dram_arb_pick.sv
// Grant selection between the CPU port (0) and the loader port (1).
// DRAM_ARB_RR_EN selects round-robin with a last-grant register; otherwise port 0 has fixed priority.
module dram_arb_pick
    import dram_arb_pkg::*;
(
`ifdef DRAM_ARB_RR_EN
    input  logic gclk,
    input  logic rst,
    input  logic take,
`endif
    input  logic req0,
    input  logic req1,
    output logic gnt
);

`ifdef DRAM_ARB_RR_EN
    logic last;

    // Reset to port 1 so the first contention after reset goes to port 0.
    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            last <= PORT1;
        end else if (take) begin
            last <= gnt;
        end
    end

    always_comb begin
        gnt = PORT0;
        if (req1 && (!req0 || last == PORT0)) begin
            gnt = PORT1;
        end
    end
`else
    always_comb begin
        gnt = PORT0;
        if (req1 && !req0) begin
            gnt = PORT1;
        end
    end
`endif

endmodule

// File: rtl/dram_arbiter.sv
// Two-port arbiter in front of a synchronous single-port RAM (1-cycle read latency).
// Arbitration policy is set by DRAM_ARB_RR_EN (round-robin) or fixed port-0 priority when undefined.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int AW           = DEF_AW,
    parameter int DW           = DEF_DW,
    parameter int SETUP_CYCLES = 1
) (
    input  logic          gclk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          wea,
    output logic [AW-1:0] daddr,
    output logic [DW-1:0] ddataout,
    input  logic [DW-1:0] ddatain
);

    localparam logic [1:0] SETUP_LAST = 2'(SETUP_CYCLES - 1);

    state_t        state;
    logic [1:0]    cnt;
    logic          gnt;
    logic          gnt_q;
    logic          any_req;
    logic          hold_we;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_wdata;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    assign any_req = req0 | req1;

`ifdef DRAM_ARB_RR_EN
    logic take;
    assign take = (state == S_IDLE) && any_req;
`endif

    dram_arb_pick u_pick (
`ifdef DRAM_ARB_RR_EN
        .gclk (gclk),
        .rst  (rst),
        .take (take),
`endif
        .req0 (req0),
        .req1 (req1),
        .gnt  (gnt)
    );

    always_comb begin
        sel_we    = we0;
        sel_addr  = addr0;
        sel_wdata = wdata0;
        if (gnt == PORT1) begin
            sel_we    = we1;
            sel_addr  = addr1;
            sel_wdata = wdata1;
        end
    end

    // The RAM address and write data come only from the holding registers,
    // so they cannot move while a transaction is in flight.
    assign daddr    = hold_addr;
    assign ddataout = hold_wdata;

    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 2'd0;
            gnt_q      <= PORT0;
            hold_we    <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            wea        <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            wea  <= 1'b0;
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        gnt_q      <= gnt;
                        hold_we    <= sel_we;
                        hold_addr  <= sel_addr;
                        hold_wdata <= sel_wdata;
                        cnt        <= 2'd0;
                        state      <= sel_we ? S_SETUP : S_READ;
                    end
                end
                S_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        wea   <= hold_we;
                        state <= S_WRITE;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                S_WRITE: begin
                    ack0  <= (gnt_q == PORT0);
                    ack1  <= (gnt_q == PORT1);
                    state <= S_ACK;
                end
                S_READ: begin
                    state <= S_RDATA;
                end
                S_RDATA: begin
                    if (gnt_q == PORT1) begin
                        rdata1 <= ddatain;
                    end else begin
                        rdata0 <= ddatain;
                    end
                    ack0  <= (gnt_q == PORT0);
                    ack1  <= (gnt_q == PORT1);
                    state <= S_ACK;
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: scoreboard of expected acks and RAM writes,
// plus a second instance with SETUP_CYCLES=3 for cycle-exact setup timing.
module tb_dram_arbiter;

    localparam int SC = 1;

    logic       gclk = 1'b0;
    logic       rst  = 1'b1;
    logic [15:0] cyc = 16'd0;

    logic       req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [7:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
    logic       ack0, ack1, wea;
    logic [7:0] rdata0, rdata1, daddr, ddataout;
    logic [7:0] ddatain = 0;

    logic       req0_b = 0, we0_b = 0;
    logic [7:0] addr0_b = 0, wdata0_b = 0;
    logic       ack0_b, ack1_b, wea_b;
    logic [7:0] rdata0_b, rdata1_b, daddr_b, ddataout_b;
    logic [7:0] ddatain_b = 0;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] ref_mem [256];
    logic [7:0] rd_m [2];
    logic       exp_last;

    logic [26:0] exp_q [$];
    logic [32:0] wr_q [$];

    logic [7:0] c_data0 [3];
    logic [7:0] c_data1 [3];

    int n_checks = 0;
    int n_fail   = 0;

    dram_arbiter #(.AW(8), .DW(8), .SETUP_CYCLES(SC)) dut (
        .gclk(gclk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .wea(wea), .daddr(daddr), .ddataout(ddataout), .ddatain(ddatain)
    );

    dram_arbiter #(.AW(8), .DW(8), .SETUP_CYCLES(3)) dut_b (
        .gclk(gclk), .rst(rst),
        .req0(req0_b), .we0(we0_b), .addr0(addr0_b), .wdata0(wdata0_b), .ack0(ack0_b), .rdata0(rdata0_b),
        .req1(1'b0), .we1(1'b0), .addr1(8'h00), .wdata1(8'h00), .ack1(ack1_b), .rdata1(rdata1_b),
        .wea(wea_b), .daddr(daddr_b), .ddataout(ddataout_b), .ddatain(ddatain_b)
    );

    // Clock, cycle counter and RAM models
    always #5 gclk = ~gclk;

    always @(posedge gclk) begin
        cyc <= cyc + 16'd1;
        if (wea) mem_a[daddr] <= ddataout;
        ddatain <= mem_a[daddr];
        if (wea_b) mem_b[daddr_b] <= ddataout_b;
        ddatain_b <= mem_b[daddr_b];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic p, input logic r, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
        if (p) begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    task automatic wait_ack(input logic p, input string tag);
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge gclk);
            if (p ? ack1 : ack0) got = 1;
        end
        check(tag, {31'd0, got}, 32'd1);
    endtask

    // Single uncontended transaction with exact latency checking.
    task automatic run_txn(input logic p, input logic w, input logic [7:0] a, input logic [7:0] d);
        @(negedge gclk);
        exp_q.push_back({p, w, 1'b1, cyc, (w ? d : ref_mem[a])});
        if (w) begin
            wr_q.push_back({1'b1, cyc, a, d});
            ref_mem[a] = d;
        end
        exp_last = p;
        drive(p, 1'b1, w, a, d);
        wait_ack(p, "txn_ack_wait");
        drive(p, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic port_seq(input logic p);
        for (int i = 0; i < 3; i++) begin
            drive(p, 1'b1, 1'b1, (p ? 8'h30 : 8'h20) + 8'(i), p ? c_data1[i] : c_data0[i]);
            wait_ack(p, "cont_ack_wait");
        end
        drive(p, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    // Both ports issue three writes each, holding req across acks.
    task automatic run_contention();
        int n0 = 3, n1 = 3, i0 = 0, i1 = 0;
        logic w;
        logic [7:0] a, d;
        for (int i = 0; i < 3; i++) begin
            c_data0[i] = 8'($urandom_range(0, 255));
            c_data1[i] = 8'($urandom_range(0, 255));
        end
        @(negedge gclk);
        while (n0 > 0 || n1 > 0) begin
            if (n0 > 0 && n1 > 0) begin
`ifdef DRAM_ARB_RR_EN
                w = ~exp_last;
`else
                w = 1'b0;
`endif
            end else begin
                w = (n0 > 0) ? 1'b0 : 1'b1;
            end
            if (w) begin
                a = 8'h30 + 8'(i1); d = c_data1[i1]; i1++; n1--;
            end else begin
                a = 8'h20 + 8'(i0); d = c_data0[i0]; i0++; n0--;
            end
            exp_q.push_back({w, 1'b1, 1'b0, cyc, d});
            wr_q.push_back({1'b0, cyc, a, d});
            ref_mem[a] = d;
            exp_last = w;
        end
        fork
            port_seq(1'b0);
            port_seq(1'b1);
        join
    endtask

    // Scoreboard: every wea pulse and every ack must match a queued expectation.
    always @(negedge gclk) begin
        logic [32:0] wr;
        logic [26:0] e;
        if (!rst) begin
            if (ack0 && ack1) check("ack_both", 32'd1, 32'd0);
            if (wea) begin
                if (wr_q.size() == 0) begin
                    check("wea_unexpected", {31'd0, wea}, 32'd0);
                end else begin
                    wr = wr_q.pop_front();
                    check("wea_daddr", {24'd0, daddr}, {24'd0, wr[15:8]});
                    check("wea_ddataout", {24'd0, ddataout}, {24'd0, wr[7:0]});
                    if (wr[32]) check("wea_cycle", {16'd0, cyc}, {16'd0, wr[31:16] + 16'(SC + 1)});
                end
            end
            if (ack0 || ack1) begin
                if (exp_q.size() == 0) begin
                    check("ack_unexpected", {30'd0, ack1, ack0}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_port", {31'd0, ack1}, {31'd0, e[26]});
                    if (e[24]) check("ack_cycle", {16'd0, cyc},
                                     {16'd0, e[23:8] + (e[25] ? 16'(SC + 2) : 16'd3)});
                    if (!e[25]) rd_m[e[26]] = e[7:0];
                    check("rdata0", {24'd0, rdata0}, {24'd0, rd_m[0]});
                    check("rdata1", {24'd0, rdata1}, {24'd0, rd_m[1]});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'h00; mem_b[i] = 8'h00; ref_mem[i] = 8'h00;
        end
        rd_m[0] = 8'h00; rd_m[1] = 8'h00;
        exp_last = 1'b1;

        rst = 1'b1;
        repeat (3) @(negedge gclk);
        check("rst_wea", {31'd0, wea}, 32'd0);
        check("rst_acks", {30'd0, ack1, ack0}, 32'd0);
        check("rst_daddr", {24'd0, daddr}, 32'd0);
        check("rst_rdata", {16'd0, rdata1, rdata0}, 32'd0);
        rst = 1'b0;

        // Port 0 write of 0xA5 to 0x12, then port 1 reads it back.
        run_txn(1'b0, 1'b1, 8'h12, 8'hA5);
        run_txn(1'b1, 1'b0, 8'h12, 8'h00);
        run_txn(1'b0, 1'b0, 8'h12, 8'h00);

        run_contention();
        run_txn(1'b1, 1'b0, 8'h20, 8'h00);
        run_txn(1'b0, 1'b0, 8'h31, 8'h00);
        run_txn(1'b1, 1'b0, 8'h32, 8'h00);

        for (int i = 0; i < 8; i++) begin
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'h50 + 8'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        end

        // SETUP_CYCLES=3 instance: write 0x7F to 0x40, then read it back.
        @(negedge gclk);
        req0_b = 1'b1; we0_b = 1'b1; addr0_b = 8'h40; wdata0_b = 8'h7F;
        for (int k = 1; k <= 6; k++) begin
            @(negedge gclk);
            check("b_wea", {31'd0, wea_b}, {31'd0, k == 4});
            check("b_ack", {31'd0, ack0_b}, {31'd0, k == 5});
            if (k <= 4) check("b_daddr", {24'd0, daddr_b}, 32'h40);
            if (k == 4) check("b_ddataout", {24'd0, ddataout_b}, 32'h7F);
            if (k == 5) req0_b = 1'b0;
        end
        @(negedge gclk);
        req0_b = 1'b1; we0_b = 1'b0; addr0_b = 8'h40;
        for (int k = 1; k <= 4; k++) begin
            @(negedge gclk);
            check("b_rd_ack", {31'd0, ack0_b}, {31'd0, k == 3});
            if (k == 3) begin
                check("b_rdata0", {24'd0, rdata0_b}, 32'h7F);
                req0_b = 1'b0;
            end
        end

        // Reset during SETUP of a write to 0x60: abandoned, nothing written.
        @(negedge gclk);
        drive(1'b0, 1'b1, 1'b1, 8'h60, 8'h99);
        @(negedge gclk);
        #1 rst = 1'b1;
        #1;
        check("midrst_wea", {31'd0, wea}, 32'd0);
        check("midrst_acks", {30'd0, ack1, ack0}, 32'd0);
        check("midrst_rdata", {16'd0, rdata1, rdata0}, 32'd0);
        check("midrst_daddr", {24'd0, daddr}, 32'd0);
        check("midrst_ddataout", {24'd0, ddataout}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        rd_m[0] = 8'h00; rd_m[1] = 8'h00;
        exp_last = 1'b1;
        @(negedge gclk);
        rst = 1'b0;
        repeat (6) @(negedge gclk);

        run_txn(1'b0, 1'b0, 8'h12, 8'h00);
        run_txn(1'b1, 1'b0, 8'h60, 8'h00);
        run_txn(1'b1, 1'b1, 8'h61, 8'h3C);
        run_txn(1'b0, 1'b0, 8'h61, 8'h00);

        repeat (5) @(negedge gclk);
        check("exp_q_drained", exp_q.size(), 32'd0);
        check("wr_q_drained", wr_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
